// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath width, mul/div op encodings and FSM states.
package mips_pkg;

  localparam int unsigned MIPS_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FIXUP = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared shift datapath: radix-2 shift-add multiply or
// restoring shift-subtract divide on a {upper, lower} 2*WIDTH accumulator.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               div,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               qbit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    qbit     = 1'b0;
    acc_next = '0;
    if (div) begin
      // Quotient bit is returned separately; the LSB of acc_next is left clear.
      qbit     = ~trial[WIDTH];
      acc_next = {(qbit ? trial[WIDTH-1:0] : acc[2*WIDTH-2:WIDTH-1]), acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Operates on magnitudes for WIDTH cycles, then applies sign fixup in FIXUP.
module mips_muldiv
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = MIPS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]      CNT_LOAD = CW'(WIDTH);
  localparam logic [WIDTH-1:0]   ONE      = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE2     = (2*WIDTH)'(1);

  md_state_e state, state_next;
  md_op_e    op_e;

  logic               signed_op, div_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [CW-1:0]      cnt;
  logic               div_q, neg_res, neg_rem, dz;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc, step_acc, prod_fix;
  logic               qbit;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    op_e      = md_op_e'(op);
    signed_op = (op_e == MD_MULT) || (op_e == MD_DIV);
    div_op    = (op_e == MD_DIV)  || (op_e == MD_DIVU);
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_mag     = a_neg ? (~a + ONE) : a;
    b_mag     = b_neg ? (~b + ONE) : b;
  end

  always_comb begin
    prod_fix = neg_res ? (~acc + ONE2) : acc;
    quot_fix = neg_res ? (~acc[WIDTH-1:0] + ONE) : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + ONE) : acc[2*WIDTH-1:WIDTH];
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .opnd     (opnd),
    .div      (div_q),
    .acc_next (step_acc),
    .qbit     (qbit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == CNT_ONE) state_next = FIXUP;
      FIXUP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      div_q   <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
      opnd    <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            div_q   <= div_op;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            dz      <= div_op && (b == '0);
            opnd    <= div_op ? b_mag : a_mag;
            acc     <= {{WIDTH{1'b0}}, (div_op ? a_mag : b_mag)};
            cnt     <= CNT_LOAD;
            busy    <= 1'b1;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: begin
          acc <= {step_acc[2*WIDTH-1:1], step_acc[0] | qbit};
          cnt <= cnt - CNT_ONE;
        end
        FIXUP: begin
          busy <= 1'b0;
          done <= 1'b1;
          // Divide by zero leaves remainder = |a|, so rem_fix already restores a.
          if (div_q) begin
            hi <= rem_fix;
            lo <= dz ? '1 : quot_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed-vector bench for mips_muldiv with hand-computed HI/LO results.
module tb_mips_muldiv;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  mips_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Launch one op and wait (bounded) for done; poke >= 0 injects a DIV start
  // plus an MTLO at that cycle of the run, both of which must be ignored.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit with_moves, input int poke,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int bc;
    bit seen;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    if (with_moves) begin
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_BEEF;
    end
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    bc = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) bc++;
        if (i == 2 || (poke >= 0 && i == poke + 3)) begin
          check({tag, "_hold_hi"}, hi, cur_hi);
          check({tag, "_hold_lo"}, lo, cur_lo);
        end
        if (poke >= 0 && i == poke) begin
          start = 1'b1; op = MD_DIV; a = 32'd9; b = 32'd3;
          mtlo = 1'b1; wdata = 32'h0000_DEAD;
        end
        if (poke >= 0 && i == poke + 1) begin
          start = 1'b0; mtlo = 1'b0;
        end
        @(negedge clk);
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, 32'(bc), 32'd33);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    cur_hi = exp_hi;
    cur_lo = exp_lo;
  endtask

  initial begin
    bit seen;
    rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op("mult_7_m3", MD_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0, -1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    @(negedge clk);
    check("mult_7_m3_done_pulse", 32'(done), 32'd0);
    check("mult_7_m3_busy_low", 32'(busy), 32'd0);

    run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, 1'b0, -1, 32'd2, 32'd14);
    run_op("divu_by0", MD_DIVU, 32'd100, 32'd0, 1'b0, -1, 32'h0000_0064, 32'hFFFF_FFFF);
    run_op("div_m7_by0", MD_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0, -1, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_min_m1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, 32'd0, 32'h8000_0000);

    run_op("multu_busy_poke", MD_MULTU, 32'd3, 32'd5, 1'b0, 9, 32'd0, 32'd15);

    @(negedge clk);
    mthi = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_hi", hi, 32'h0000_1234);
    check("mthi_lo_kept", lo, 32'd15);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_5A5A;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mthilo_hi", hi, 32'h0000_5A5A);
    check("mthilo_lo", lo, 32'h0000_5A5A);
    cur_hi = 32'h0000_5A5A;
    cur_lo = 32'h0000_5A5A;

    run_op("start_wins", MD_MULTU, 32'd2, 32'd3, 1'b1, -1, 32'd0, 32'd6);

    // Back-to-back: start asserted in the done cycle of the previous op.
    op = MD_DIVU; a = 32'd50; b = 32'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    check("b2b_done_seen", 32'(seen), 32'd1);
    check("b2b_hi", hi, 32'd2);
    check("b2b_lo", lo, 32'd6);
    cur_hi = 32'd2;
    cur_lo = 32'd6;

    @(negedge clk);
    op = MD_MULT; a = 32'd7; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("abort_pre_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_quiet", 32'(seen), 32'd0);
    check("abort_hi_hold", hi, 32'd0);
    cur_hi = '0;
    cur_lo = '0;

    run_op("mult_after_rst", MD_MULT, 32'd7, 32'd7, 1'b0, -1, 32'd0, 32'd49);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_muldiv.md
# mips_muldiv

Iterative multiply/divide unit for the MIPS core, sitting directly downstream of the `DataPath` register-read stage. It consumes the rs/rt operands for MULT, MULTU, DIV and DIVU and produces the architectural HI/LO registers read back by MFHI/MFLO. A single shared shift datapath performs one step per cycle. Exposing `busy` lets the datapath stall HI/LO consumers.

## Interface
- Reset: one clock; reset is asynchronous and active-low.
- `WIDTH`, default 32: operand and HI/LO width.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: launches the operation selected by `op`.
- `op`, input, 2: operation select.
  - 00 = MULT
  - 01 = MULTU
  - 10 = DIV
  - 11 = DIVU
- `a`, input, WIDTH: rs operand (multiplicand or dividend).
- `b`, input, WIDTH: rt operand (multiplier or divisor).
- `mthi`, input, 1: write `wdata` into HI.
- `mtlo`, input, 1: write `wdata` into LO.
- `wdata`, input, WIDTH: data for MTHI/MTLO.
- `busy`, output, 1: an operation is in flight.
- `done`, output, 1: one-cycle pulse marking the cycle HI/LO first hold a new result.
- `hi`, output, WIDTH: HI register.
- `lo`, output, WIDTH: LO register.

## Operation
- FSM states: IDLE, RUN, FIXUP.
- IDLE → RUN on `start`. The edge that samples `start` captures:
  - `op`,
  - the magnitudes |a| and |b| for signed ops, or the raw values for unsigned ops,
  - the result sign flags,
  - a step counter loaded to WIDTH.
- RUN performs one step per cycle and decrements the counter.
  - Multiply: radix-2 shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract yielding quotient and remainder.
- RUN → FIXUP when the counter reaches 0 after WIDTH steps.
- FIXUP → IDLE unconditionally. On that edge it writes HI/LO and applies the sign fixup:
  - MULT: the 64-bit product is negated if the operand signs differ; HI = upper 32 bits, LO = lower 32 bits.
  - DIV: LO = quotient, negated if the signs differ; HI = remainder, carrying the sign of the dividend.
  - DIVU/MULTU: no fixup.
- Divide by zero (b = 0): LO = all ones, HI = `a` unchanged. No exception is raised.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- `start` while busy is ignored, and the in-flight operation is unaffected.
- `mthi`/`mtlo` in IDLE write on the next edge; both may be asserted together. They are ignored while busy.
- `start` together with `mthi`/`mtlo` in IDLE: `start` wins and the moves are dropped.
- `hi`/`lo` hold their values between operations. Intermediate accumulator contents are never visible on `hi`/`lo`.

## Timing
- Reset values: `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0, state = IDLE, counter = 0.
- Reset asserted mid-operation aborts it immediately. No HI/LO update and no `done` pulse follow.
- Let E0 be the edge that samples `start`.
  - `busy` = 1 from E0.
  - Steps occur on edges E1..E32.
  - FIXUP occurs on E33: `hi`/`lo` update, `busy` falls to 0, and `done` = 1 for exactly the cycle after E33.
  - Latency is therefore 33 cycles from start-sample to result.
- Back-to-back: `start` may be asserted in the `done` cycle and is accepted at that cycle's edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `mips_pkg` holds:
  - the `op` encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU),
  - the FSM state enum,
  - the WIDTH constant shared with `DataPath`.
- Sub-module `muldiv_step`: purely combinational single-step logic. Given accumulator, operand and mode, it returns the next accumulator and the quotient bit.
- The FSM, counter, sign flags and HI/LO registers stay in `mips_muldiv`.

## Test plan
- MULT a = 7, b = 0xFFFFFFFD (−3) → after 33 cycles hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; `done` high for one cycle; `busy` high for exactly 33 cycles.
- MULTU a = b = 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001.
- DIV a = 0xFFFFFFF9 (−7), b = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU a = 100, b = 7 → lo = 14, hi = 2.
- DIVU a = 100, b = 0 → lo = 0xFFFFFFFF, hi = 0x00000064. DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- MULTU 3·5 running; at cycle 10 assert `start` with op = DIV, a = 9, b = 3, and assert `mtlo` with wdata = 0xDEAD → both are ignored; final hi = 0, lo = 15. Afterwards in IDLE, assert `mthi` = 0x1234 → hi = 0x1234 next cycle.
- Start MULT 7·7, then pull `rst` low at cycle 20 → `busy` = 0 and hi = lo = 0 immediately, and no `done` pulse follows. Release reset; `start` is accepted on the next edge.
